// File: rtl/mem_lsu_pkg.sv
// Shared widths, memory sub-op codes and LSU state encodings for the memory-access stage.
// Also holds small decode helpers used by both the LSU and its alignment logic.
package mem_lsu_pkg;

  localparam int unsigned REG_W      = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALUOP_W    = 8;

  localparam logic [ALUOP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [ALUOP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [ALUOP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [ALUOP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [ALUOP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [ALUOP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [ALUOP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [2:0] EXE_RES_LOAD_STORE = 3'b111;

  localparam logic [1:0] LSU_IDLE = 2'b00;
  localparam logic [1:0] LSU_BUSY = 2'b01;
  localparam logic [1:0] LSU_DONE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = LSU_IDLE,
    ST_BUSY = LSU_BUSY,
    ST_DONE = LSU_DONE
  } lsu_state_e;

  function automatic logic is_load(input logic [ALUOP_W-1:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [ALUOP_W-1:0] op);
    case (op)
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_mem_op(input logic [ALUOP_W-1:0] op);
    return is_load(op) | is_store(op);
  endfunction

  // Halfwords need an even address, words need a word-aligned address.
  function automatic logic is_misaligned(input logic [ALUOP_W-1:0] op, input logic [1:0] off);
    case (op)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return off[0];
      EXE_LW_OP, EXE_SW_OP:             return off != 2'b00;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Big-endian lane logic: byte-lane select and store replication, plus
// lane extraction and sign/zero extension of load data.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [ALUOP_W-1:0] op,
  input  logic [1:0]         off,
  input  logic [REG_W-1:0]   st_data,
  input  logic [REG_W-1:0]   ld_raw,
  output logic [3:0]         sel,
  output logic [REG_W-1:0]   st_wdata,
  output logic [REG_W-1:0]   ld_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v   = 8'h00;
    half_v   = 16'h0000;
    sel      = 4'b0000;
    st_wdata = '0;
    ld_data  = '0;

    // Offset 00 is the most significant lane.
    case (off)
      2'd0:    byte_v = ld_raw[31:24];
      2'd1:    byte_v = ld_raw[23:16];
      2'd2:    byte_v = ld_raw[15:8];
      default: byte_v = ld_raw[7:0];
    endcase
    half_v = off[1] ? ld_raw[15:0] : ld_raw[31:16];

    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP:  sel = 4'b1000 >> off;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP:  sel = off[1] ? 4'b0011 : 4'b1100;
      EXE_LW_OP, EXE_SW_OP:              sel = 4'b1111;
      default:                           sel = 4'b0000;
    endcase

    case (op)
      EXE_SB_OP: st_wdata = {4{st_data[7:0]}};
      EXE_SH_OP: st_wdata = {2{st_data[15:0]}};
      EXE_SW_OP: st_wdata = st_data;
      default:   st_wdata = '0;
    endcase

    case (op)
      EXE_LB_OP:  ld_data = {{24{byte_v[7]}}, byte_v};
      EXE_LBU_OP: ld_data = {24'h000000, byte_v};
      EXE_LH_OP:  ld_data = {{16{half_v[15]}}, half_v};
      EXE_LHU_OP: ld_data = {16'h0000, half_v};
      EXE_LW_OP:  ld_data = ld_raw;
      default:    ld_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access stage: runs a req/ack bus transaction for loads and stores,
// stalling the pipe until done; non-memory ops pass straight through.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ALUOP_W-1:0]    aluop_i,
  input  logic [REG_W-1:0]      mem_addr_i,
  input  logic [REG_W-1:0]      reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [REG_W-1:0]      wdata_i,
  input  logic                  stall_i,
  input  logic [REG_W-1:0]      bus_rdata_i,
  input  logic                  bus_ack_i,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [REG_W-1:0]      bus_addr_o,
  output logic [3:0]            bus_sel_o,
  output logic [REG_W-1:0]      bus_wdata_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [REG_W-1:0]      wdata_o,
  output logic                  stallreq_o,
  output logic                  misalign_o
);

  lsu_state_e          state;
  logic [ALUOP_W-1:0]  op_q;
  logic [1:0]          off_q;
  logic [REG_W-1:0]    rdata_q;

  logic                mem_op;
  logic                misaligned;
  logic                issue;
  logic [ALUOP_W-1:0]  al_op;
  logic [1:0]          al_off;
  logic [3:0]          al_sel;
  logic [REG_W-1:0]    al_wdata;
  logic [REG_W-1:0]    al_ldata;

  assign mem_op     = is_mem_op(aluop_i);
  assign misaligned = mem_op & is_misaligned(aluop_i, mem_addr_i[1:0]);
  assign issue      = (state == ST_IDLE) & mem_op & ~misaligned;

  // Live inputs drive lane selection at issue; the captured op drives load extension.
  assign al_op  = (state == ST_IDLE) ? aluop_i : op_q;
  assign al_off = (state == ST_IDLE) ? mem_addr_i[1:0] : off_q;

  mem_lsu_align u_align (
    .op       (al_op),
    .off      (al_off),
    .st_data  (reg2_i),
    .ld_raw   (rdata_q),
    .sel      (al_sel),
    .st_wdata (al_wdata),
    .ld_data  (al_ldata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_sel_o   <= 4'b0000;
      bus_wdata_o <= '0;
      op_q        <= '0;
      off_q       <= 2'b00;
      rdata_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= is_store(aluop_i);
            bus_addr_o  <= {mem_addr_i[REG_W-1:2], 2'b00};
            bus_sel_o   <= al_sel;
            bus_wdata_o <= al_wdata;
            op_q        <= aluop_i;
            off_q       <= mem_addr_i[1:0];
            state       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus_ack_i) begin
            rdata_q   <= bus_rdata_i;
            bus_req_o <= 1'b0;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Holding here while stalled keeps the same instruction from reissuing.
          if (!stall_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    stallreq_o = 1'b0;
    misalign_o = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          wd_o    = wd_i;
          wdata_o = wdata_i;
          if (!mem_op) begin
            wreg_o = wreg_i;
          end else if (misaligned) begin
            misalign_o = 1'b1;
          end else begin
            stallreq_o = 1'b1;
          end
        end
        ST_BUSY: begin
          wd_o       = wd_i;
          stallreq_o = 1'b1;
        end
        ST_DONE: begin
          wd_o    = wd_i;
          wreg_o  = wreg_i;
          wdata_o = is_load(op_q) ? al_ldata : wdata_i;
        end
        default: begin
          wd_o = wd_i;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: byte-addressed reference memory plus a bus-side device memory,
// directed scenarios followed by randomized back-to-back memory and ALU ops.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i, wdata_i, bus_rdata_i;
  logic [4:0]  wd_i;
  logic        wreg_i, stall_i, bus_ack_i;
  logic        bus_req_o, bus_we_o, wreg_o, stallreq_o, misalign_o;
  logic [31:0] bus_addr_o, bus_wdata_o, wdata_o;
  logic [3:0]  bus_sel_o;
  logic [4:0]  wd_o;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .stall_i(stall_i),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .bus_req_o(bus_req_o),
    .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o),
    .bus_wdata_o(bus_wdata_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .stallreq_o(stallreq_o), .misalign_o(misalign_o)
  );

  localparam logic [7:0] OR_OP = 8'b0010_0101;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference memory seen by the program; device memory seen on the bus.
  logic [7:0]  ref_mem [64];
  logic [31:0] dev_mem [16];

  logic [7:0] op_tab  [9] = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
                              EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, OR_OP};
  int         sz_tab  [9] = '{1, 1, 2, 2, 4, 1, 2, 4, 0};
  bit         ld_tab  [9] = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
  bit         sgn_tab [9] = '{1, 0, 1, 0, 0, 0, 0, 0, 0};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic seed_word(input logic [31:0] addr, input logic [31:0] val);
    dev_mem[addr[5:2]] = val;
    for (int i = 0; i < 4; i++) ref_mem[{addr[5:2], 2'(i)}] = val[31-8*i -: 8];
  endtask

  // Issues one instruction starting just after a rising edge; returns just after a rising edge.
  task automatic run_op(input int k, input logic [31:0] addr, input logic [31:0] r2,
                        input int delay, input int hold);
    int          sz = sz_tab[k];
    logic [1:0]  off = addr[1:0];
    logic [4:0]  wd = 5'($urandom);
    logic        wr = 1'($urandom);
    logic [31:0] alu = $urandom;
    logic [3:0]  exp_sel = 4'b0000;
    logic [31:0] exp_bw, exp_ld, word;
    int          stalls = 0, reqs = 0, busy = 0;
    logic        prev_req = 1'b0;

    aluop_i = op_tab[k]; mem_addr_i = addr; reg2_i = r2;
    wd_i = wd; wreg_i = wr; wdata_i = alu; stall_i = 1'b0; bus_ack_i = 1'b0;
    @(negedge clk);

    if (sz == 0) begin
      check_eq("pass_wdata", wdata_o, alu);
      check_eq("pass_wreg", 32'(wreg_o), 32'(wr));
      check_eq("pass_wd", 32'(wd_o), 32'(wd));
      check_eq("pass_stall", 32'(stallreq_o), 0);
      check_eq("pass_req", 32'(bus_req_o), 0);
      @(posedge clk); #1;
      return;
    end

    if ((sz == 2 && off[0]) || (sz == 4 && off != 2'b00)) begin
      check_eq("mis_flag", 32'(misalign_o), 1);
      check_eq("mis_wreg", 32'(wreg_o), 0);
      check_eq("mis_stall", 32'(stallreq_o), 0);
      @(posedge clk); #1;
      check_eq("mis_req", 32'(bus_req_o), 0);
      return;
    end

    check_eq("align_flag", 32'(misalign_o), 0);
    for (int i = 0; i < sz; i++) exp_sel[3 - (int'(off) + i)] = 1'b1;
    exp_bw = (sz == 1) ? {4{r2[7:0]}} : (sz == 2) ? {2{r2[15:0]}} : r2;
    exp_ld = 32'h0;
    for (int i = 0; i < sz; i++) exp_ld = {exp_ld[23:0], ref_mem[addr[5:0] + 6'(i)]};
    if (sgn_tab[k] && sz == 1) exp_ld = {{24{exp_ld[7]}}, exp_ld[7:0]};
    if (sgn_tab[k] && sz == 2) exp_ld = {{16{exp_ld[15]}}, exp_ld[15:0]};
    if (!ld_tab[k])
      for (int i = 0; i < sz; i++) ref_mem[addr[5:0] + 6'(i)] = r2[8*(sz-1-i) +: 8];

    while (stallreq_o === 1'b1 && stalls < 40) begin
      stalls++;
      if (bus_req_o && !prev_req) reqs++;
      prev_req = bus_req_o;
      if (bus_req_o) begin
        busy++;
        check_eq("bus_addr", bus_addr_o, {addr[31:2], 2'b00});
        check_eq("bus_sel", 32'(bus_sel_o), 32'(exp_sel));
        if (busy == 1) begin
          check_eq("bus_we", 32'(bus_we_o), ld_tab[k] ? 0 : 1);
          if (!ld_tab[k]) check_eq("bus_wdata", bus_wdata_o, exp_bw);
        end
        if (busy == delay + 1) begin
          word = dev_mem[bus_addr_o[5:2]];
          if (bus_we_o)
            for (int b = 0; b < 4; b++)
              if (bus_sel_o[3-b]) word[31-8*b -: 8] = bus_wdata_o[31-8*b -: 8];
          dev_mem[bus_addr_o[5:2]] = word;
          bus_rdata_i = word;
          bus_ack_i = 1'b1;
        end else begin
          bus_rdata_i = $urandom;
          bus_ack_i = 1'b0;
        end
      end
      @(negedge clk);
    end
    bus_ack_i = 1'b0;

    check_eq("stall_cycles", 32'(stalls), 32'(2 + delay));
    if (stalls >= 40) begin
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      return;
    end
    check_eq("done_wreg", 32'(wreg_o), 32'(wr));
    check_eq("done_wd", 32'(wd_o), 32'(wd));
    check_eq("done_wdata", wdata_o, ld_tab[k] ? exp_ld : alu);
    for (int h = 0; h < hold; h++) begin
      stall_i = 1'b1;
      @(negedge clk);
      if (bus_req_o && !prev_req) reqs++;
      prev_req = bus_req_o;
      check_eq("hold_stallreq", 32'(stallreq_o), 0);
      check_eq("hold_wdata", wdata_o, ld_tab[k] ? exp_ld : alu);
    end
    check_eq("txn_count", 32'(reqs), 1);
    stall_i = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    aluop_i = OR_OP; mem_addr_i = 32'h0000_0104; reg2_i = 32'h1234_5678;
    wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'hCAFE_F00D;
    for (int w = 0; w < 16; w++) seed_word(32'(w * 4), $urandom);

    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rst_req", 32'(bus_req_o), 0);
    check_eq("rst_we", 32'(bus_we_o), 0);
    check_eq("rst_addr", bus_addr_o, 0);
    check_eq("rst_sel", 32'(bus_sel_o), 0);
    check_eq("rst_bwdata", bus_wdata_o, 0);
    check_eq("rst_wdata", wdata_o, 0);
    check_eq("rst_wreg", 32'(wreg_o), 0);
    check_eq("rst_wd", 32'(wd_o), 0);
    check_eq("rst_stall", 32'(stallreq_o), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed scenarios
    run_op(8, 32'h0000_0010, 32'h0, 0, 0);
    seed_word(32'h0000_0100, 32'h1280_3456);
    run_op(0, 32'h0000_0101, 32'h0, 1, 0);
    run_op(1, 32'h0000_0101, 32'h0, 0, 0);
    run_op(6, 32'h0000_0202, 32'hAAAA_BEEF, 0, 0);
    run_op(4, 32'h0000_0302, 32'h0, 0, 0);
    run_op(4, 32'h0000_0308, 32'h0, 2, 3);
    run_op(2, 32'h0000_0202, 32'h0, 0, 1);

    // Reset during BUSY, then a late ack
    aluop_i = EXE_LW_OP; mem_addr_i = 32'h0000_0400; wreg_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("rb_req_before", 32'(bus_req_o), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rb_req", 32'(bus_req_o), 0);
    check_eq("rb_stall", 32'(stallreq_o), 0);
    check_eq("rb_wdata", wdata_o, 0);
    check_eq("rb_wreg", 32'(wreg_o), 0);
    bus_ack_i = 1'b1; bus_rdata_i = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    rst = 1'b0; aluop_i = OR_OP; wdata_i = 32'h0000_FFFF; wd_i = 5'd3; wreg_i = 1'b1;
    @(negedge clk);
    check_eq("rb_late_req", 32'(bus_req_o), 0);
    check_eq("rb_late_stall", 32'(stallreq_o), 0);
    check_eq("rb_late_pass", wdata_o, 32'h0000_FFFF);
    bus_ack_i = 1'b0;
    @(posedge clk); #1;
    run_op(4, 32'h0000_0400, 32'h0, 0, 0);

    // Randomized back-to-back traffic
    for (int n = 0; n < 200; n++)
      run_op($urandom_range(0, 8), ($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(0, 63)),
             $urandom, $urandom_range(0, 3), $urandom_range(0, 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
